// File: rtl/axi_uart_lite_bridge_if.sv
// ---------------------------------------------------------------------------
// axi_uart_lite_bridge_if
// AXI4-Lite bus between the probe bridge (master) and the UART Lite core
// (slave).
//   aw*  : write address  (awaddr, awsize, awvalid / awready)
//   w*   : write data     (wdata, wstrb, wvalid / wready)
//   b*   : write response (bresp, bvalid / bready)
//   ar*  : read address   (araddr, arsize, arvalid / arready)
//   r*   : read data      (rdata, rresp, rvalid / rready)
// ---------------------------------------------------------------------------
interface axi_uart_lite_bridge_if;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arsize, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arsize, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_uart_lite_bridge.sv
// ---------------------------------------------------------------------------
// axi_uart_lite_bridge
// Connects the probe byte stream to an AXI4-Lite UART Lite core. A single
// serialised AXI master configures CTRL once after reset, then polls STATUS
// and moves one byte at a time: UART RX bytes go into a local FIFO feeding
// the probe, probe bytes are written to UART TX when it has room.
//
// Ports:
//   clk, m_aresetn              clock, async active-low reset
//   rx_valid/rx_data/rx_ready   probe -> UART byte stream
//   tx_valid/tx_data/tx_ready   UART -> probe byte stream (FIFO head)
//   m_axi                       AXI4-Lite master (axi_uart_lite_bridge_if)
//   bridge_err                  sticky: any BRESP/RRESP != OKAY since reset
//   err_count                   saturating error-response count (only with
//                               AXI_UART_BRIDGE_ERR_CNT_EN defined)
//
// Build option: `define AXI_UART_BRIDGE_ERR_CNT_EN adds err_count[7:0].
// ---------------------------------------------------------------------------
module axi_uart_lite_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h4060_0000,
  parameter logic [7:0]  CTRL_CFG  = 8'h13,
  parameter int unsigned RXQ_DEPTH = 4,
  parameter int unsigned POLL_GAP  = 8
) (
  input  logic                          clk,
  input  logic                          m_aresetn,
  input  logic                          rx_valid,
  input  logic [7:0]                    rx_data,
  output logic                          rx_ready,
  output logic                          tx_valid,
  output logic [7:0]                    tx_data,
  input  logic                          tx_ready,
  axi_uart_lite_bridge_if.master        m_axi,
  output logic                          bridge_err
`ifdef AXI_UART_BRIDGE_ERR_CNT_EN
  ,
  output logic [7:0]                    err_count
`endif
);

  localparam logic [31:0] ADDR_RX   = BASE_ADDR + 32'h0;
  localparam logic [31:0] ADDR_TX   = BASE_ADDR + 32'h4;
  localparam logic [31:0] ADDR_STAT = BASE_ADDR + 32'h8;
  localparam logic [31:0] ADDR_CTRL = BASE_ADDR + 32'hC;

  localparam int unsigned PW = (RXQ_DEPTH > 1) ? $clog2(RXQ_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(RXQ_DEPTH);
  localparam logic [15:0]   GAP_LAST = 16'(POLL_GAP - 1);

  typedef enum logic [3:0] {
    S_RESET, S_CFG_AW, S_CFG_B, S_POLL_AR, S_POLL_R, S_DECIDE,
    S_RD_AR, S_RD_R, S_WR_AW, S_WR_B, S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic          aw_done_q, aw_done_d;
  logic          w_done_q, w_done_d;
  logic [7:0]    wbyte_q, wbyte_d;
  logic          stat_rx_q, stat_rx_d;
  logic          stat_txf_q, stat_txf_d;
  logic [15:0]   gap_q, gap_d;
  logic          rx_valid_q;
  logic          err_q;

  logic [7:0]    mem_q [RXQ_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          fifo_full, fifo_empty, push, pop;

  logic          aw_valid, w_valid, b_ready, ar_valid, r_ready, rx_rdy;
  logic [31:0]   aw_addr, ar_addr, w_data;
  logic          err_set;
  logic          unused_rdata;

  assign fifo_full  = (cnt_q == FULL_CNT);
  assign fifo_empty = (cnt_q == '0);
  assign pop        = !fifo_empty && tx_ready;

  always_comb begin
    state_d    = state_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    wbyte_d    = wbyte_q;
    stat_rx_d  = stat_rx_q;
    stat_txf_d = stat_txf_q;
    gap_d      = gap_q;
    aw_valid   = 1'b0;
    w_valid    = 1'b0;
    b_ready    = 1'b0;
    ar_valid   = 1'b0;
    r_ready    = 1'b0;
    rx_rdy     = 1'b0;
    push       = 1'b0;
    aw_addr    = ADDR_TX;
    ar_addr    = ADDR_STAT;
    w_data     = {24'h0, wbyte_q};

    case (state_q)
      S_RESET: state_d = S_CFG_AW;

      // AW and W are issued together but each completes independently;
      // the done flags keep a finished channel from being re-presented.
      S_CFG_AW, S_WR_AW: begin
        aw_valid  = !aw_done_q;
        w_valid   = !w_done_q;
        if (state_q == S_CFG_AW) begin
          aw_addr = ADDR_CTRL;
          w_data  = {24'h0, CTRL_CFG};
        end
        aw_done_d = aw_done_q || m_axi.awready;
        w_done_d  = w_done_q || m_axi.wready;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = (state_q == S_CFG_AW) ? S_CFG_B : S_WR_B;
        end
      end

      S_CFG_B, S_WR_B: begin
        b_ready = 1'b1;
        if (m_axi.bvalid) begin
          // The probe byte is only consumed once the UART has accepted it.
          rx_rdy  = (state_q == S_WR_B);
          state_d = S_POLL_AR;
        end
      end

      S_POLL_AR: begin
        ar_valid = 1'b1;
        ar_addr  = ADDR_STAT;
        if (m_axi.arready) state_d = S_POLL_R;
      end

      S_POLL_R: begin
        r_ready = 1'b1;
        if (m_axi.rvalid) begin
          stat_rx_d  = m_axi.rdata[0];
          stat_txf_d = m_axi.rdata[3];
          state_d    = S_DECIDE;
        end
      end

      S_DECIDE: begin
        if (stat_rx_q && !fifo_full) begin
          state_d = S_RD_AR;
        end else if (rx_valid && !stat_txf_q) begin
          wbyte_d = rx_data;
          state_d = S_WR_AW;
        end else if (POLL_GAP == 0) begin
          state_d = S_POLL_AR;
        end else begin
          gap_d   = '0;
          state_d = S_GAP;
        end
      end

      S_RD_AR: begin
        ar_valid = 1'b1;
        ar_addr  = ADDR_RX;
        if (m_axi.arready) state_d = S_RD_R;
      end

      S_RD_R: begin
        r_ready = 1'b1;
        if (m_axi.rvalid) begin
          push    = 1'b1;
          state_d = S_POLL_AR;
        end
      end

      // A newly arriving probe byte cuts the idle gap short.
      S_GAP: begin
        if ((gap_q == GAP_LAST) || (rx_valid && !rx_valid_q)) begin
          state_d = S_POLL_AR;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end

      default: state_d = S_RESET;
    endcase
  end

  assign err_set = (b_ready && m_axi.bvalid && (m_axi.bresp != 2'b00)) ||
                   (r_ready && m_axi.rvalid && (m_axi.rresp != 2'b00));

  always_ff @(posedge clk or negedge m_aresetn) begin
    if (!m_aresetn) begin
      state_q    <= S_RESET;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      wbyte_q    <= '0;
      stat_rx_q  <= 1'b0;
      stat_txf_q <= 1'b0;
      gap_q      <= '0;
      rx_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      wbyte_q    <= wbyte_d;
      stat_rx_q  <= stat_rx_d;
      stat_txf_q <= stat_txf_d;
      gap_q      <= gap_d;
      rx_valid_q <= rx_valid;
      if (err_set) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge m_aresetn) begin
    if (!m_aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= m_axi.rdata[7:0];
  end

`ifdef AXI_UART_BRIDGE_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or negedge m_aresetn) begin
    if (!m_aresetn) begin
      err_cnt_q <= '0;
    end else if (err_set && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_count = err_cnt_q;
`else
`endif

  assign unused_rdata  = ^m_axi.rdata[31:8];

  assign tx_valid      = !fifo_empty;
  assign tx_data       = mem_q[rd_ptr_q];
  assign rx_ready      = rx_rdy;
  assign bridge_err    = err_q;

  assign m_axi.awaddr  = aw_addr;
  assign m_axi.awsize  = 3'b010;
  assign m_axi.awvalid = aw_valid;
  assign m_axi.wdata   = w_data;
  assign m_axi.wstrb   = 4'b0001;
  assign m_axi.wvalid  = w_valid;
  assign m_axi.bready  = b_ready;
  assign m_axi.araddr  = ar_addr;
  assign m_axi.arsize  = 3'b010;
  assign m_axi.arvalid = ar_valid;
  assign m_axi.rready  = r_ready;

endmodule

// File: tb/tb_axi_uart_lite_bridge.sv
// ---------------------------------------------------------------------------
// tb_axi_uart_lite_bridge
// Directed bench: the initial block plays both the probe and the UART Lite
// slave, and compares DUT behaviour against hand-computed values.
// ---------------------------------------------------------------------------
module tb_axi_uart_lite_bridge;

  localparam logic [31:0] A_RX   = 32'h4060_0000;
  localparam logic [31:0] A_TX   = 32'h4060_0004;
  localparam logic [31:0] A_STAT = 32'h4060_0008;
  localparam logic [31:0] A_CTRL = 32'h4060_000C;
  localparam int          GAPW   = 9; // DECIDE + 8 gap cycles

  logic       clk = 1'b0;
  logic       m_aresetn;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       bridge_err;
`ifdef AXI_UART_BRIDGE_ERR_CNT_EN
  logic [7:0] err_count;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int overlap  = 0;

  axi_uart_lite_bridge_if bus ();

  axi_uart_lite_bridge #(
    .BASE_ADDR (32'h4060_0000),
    .CTRL_CFG  (8'h13),
    .RXQ_DEPTH (4),
    .POLL_GAP  (8)
  ) dut (
    .clk        (clk),
    .m_aresetn  (m_aresetn),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .m_axi      (bus),
    .bridge_err (bridge_err)
`ifdef AXI_UART_BRIDGE_ERR_CNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.arvalid && bus.awvalid) overlap++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_read(input string tag, input logic [31:0] data, input logic [1:0] resp,
                          output logic [31:0] addr, output int wait_cyc);
    int n = 0;
    while (!bus.arvalid && n < 200) begin
      tick();
      n++;
    end
    check({tag, " arvalid"}, 32'(bus.arvalid), 32'd1);
    wait_cyc    = n;
    addr        = bus.araddr;
    bus.arready = 1'b1;
    tick();
    bus.arready = 1'b0;
    bus.rvalid  = 1'b1;
    bus.rdata   = data;
    bus.rresp   = resp;
    n = 0;
    while (!bus.rready && n < 20) begin
      tick();
      n++;
    end
    check({tag, " rready"}, 32'(bus.rready), 32'd1);
    tick();
    bus.rvalid = 1'b0;
    bus.rdata  = '0;
    bus.rresp  = 2'b00;
  endtask

  task automatic axi_write(input string tag, input int aw_wait,
                           output logic [31:0] addr, output logic [31:0] data,
                           output int aw_hi, output int w_hi,
                           output logic rdy_at_b, output logic rdy_after_b,
                           output logic ar_at_b);
    int   n = 0;
    logic aw_done = 1'b0;
    logic w_done  = 1'b0;
    while (!bus.awvalid && n < 200) begin
      tick();
      n++;
    end
    check({tag, " awvalid"}, 32'(bus.awvalid), 32'd1);
    addr  = bus.awaddr;
    data  = bus.wdata;
    aw_hi = 0;
    w_hi  = 0;
    n     = 0;
    while (!(aw_done && w_done) && n < 50) begin
      if (bus.awvalid) aw_hi++;
      if (bus.wvalid)  w_hi++;
      bus.awready = bus.awvalid && (n >= aw_wait);
      bus.wready  = bus.wvalid;
      if (bus.awvalid && bus.awready) aw_done = 1'b1;
      if (bus.wvalid && bus.wready)   w_done  = 1'b1;
      tick();
      n++;
    end
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    check({tag, " aw+w done"}, 32'({aw_done, w_done}), 32'd3);
    bus.bvalid = 1'b1;
    bus.bresp  = 2'b00;
    #1;
    check({tag, " bready"}, 32'(bus.bready), 32'd1);
    rdy_at_b = rx_ready;
    ar_at_b  = bus.arvalid;
    tick();
    bus.bvalid  = 1'b0;
    rdy_after_b = rx_ready;
  endtask

  logic [31:0] a, d;
  int          wc, awh, wh;
  logic        rb, ra, arb;

  initial begin
    m_aresetn   = 1'b0;
    rx_valid    = 1'b0;
    rx_data     = '0;
    tx_ready    = 1'b0;
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.bresp   = 2'b00;
    bus.bvalid  = 1'b0;
    bus.arready = 1'b0;
    bus.rdata   = '0;
    bus.rresp   = 2'b00;
    bus.rvalid  = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst awvalid", 32'(bus.awvalid), 32'd0);
    check("rst wvalid", 32'(bus.wvalid), 32'd0);
    check("rst arvalid", 32'(bus.arvalid), 32'd0);
    check("rst rready", 32'(bus.rready), 32'd0);
    check("rst rx_ready", 32'(rx_ready), 32'd0);
    check("rst tx_valid", 32'(tx_valid), 32'd0);
    check("rst bridge_err", 32'(bridge_err), 32'd0);
    m_aresetn = 1'b1;

    // Configuration write, then first STATUS poll
    axi_write("cfg", 0, a, d, awh, wh, rb, ra, arb);
    check("cfg awaddr", a, A_CTRL);
    check("cfg wdata", d, 32'h0000_0013);
    check("cfg wstrb", 32'(bus.wstrb), 32'h1);
    check("cfg awsize", 32'(bus.awsize), 32'h2);
    check("cfg arsize", 32'(bus.arsize), 32'h2);
    check("cfg rx_ready at b", 32'(rb), 32'd0);
    check("cfg arvalid at b", 32'(arb), 32'd0);
    check("cfg arvalid after b", 32'(bus.arvalid), 32'd1);

    // Probe byte 0xA5 with TX room
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    axi_read("tx poll", 32'h04, 2'b00, a, wc);
    check("tx poll araddr", a, A_STAT);
    axi_write("tx", 0, a, d, awh, wh, rb, ra, arb);
    check("tx awaddr", a, A_TX);
    check("tx wdata", d, 32'h0000_00A5);
    check("tx rx_ready at b", 32'(rb), 32'd1);
    check("tx rx_ready after b", 32'(ra), 32'd0);

    // TX full: no write, gap between polls, then write proceeds
    rx_data = 8'h5A;
    axi_read("full poll1", 32'h08, 2'b00, a, wc);
    check("full poll1 araddr", a, A_STAT);
    axi_read("full poll2", 32'h04, 2'b00, a, wc);
    check("full poll2 araddr", a, A_STAT);
    check("full poll gap", 32'(wc), 32'(GAPW));
    axi_write("full wr", 0, a, d, awh, wh, rb, ra, arb);
    check("full wr wdata", d, 32'h0000_005A);
    check("full wr rx_ready", 32'(rb), 32'd1);
    rx_valid = 1'b0;

    // RX path: fill FIFO with tx_ready low
    for (int i = 0; i < 4; i++) begin
      axi_read("fill poll", 32'h01, 2'b00, a, wc);
      check("fill poll araddr", a, A_STAT);
      axi_read("fill rd", 32'h3C + 32'(i), 2'b00, a, wc);
      check("fill rd araddr", a, A_RX);
    end
    axi_read("full fifo poll", 32'h01, 2'b00, a, wc);
    check("full fifo poll araddr", a, A_STAT);
    check("full fifo tx_valid", 32'(tx_valid), 32'd1);
    check("full fifo tx_data", 32'(tx_data), 32'h3C);
    axi_read("no 5th read", 32'h01, 2'b00, a, wc);
    check("no 5th read araddr", a, A_STAT);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    check("after pop tx_data", 32'(tx_data), 32'h3D);
    axi_read("refill poll", 32'h01, 2'b00, a, wc);
    check("refill poll araddr", a, A_STAT);
    axi_read("refill rd", 32'h40, 2'b00, a, wc);
    check("refill rd araddr", a, A_RX);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain tx_valid", 32'(tx_valid), 32'd1);
      check("drain tx_data", 32'(tx_data), 32'h3D + 32'(i));
      tick();
    end
    check("drained tx_valid", 32'(tx_valid), 32'd0);
    tx_ready = 1'b0;

    // Delayed awready, immediate wready
    rx_valid = 1'b1;
    rx_data  = 8'h77;
    axi_read("slow poll", 32'h04, 2'b00, a, wc);
    axi_write("slow aw", 2, a, d, awh, wh, rb, ra, arb);
    check("slow awvalid cycles", 32'(awh), 32'd3);
    check("slow wvalid cycles", 32'(wh), 32'd1);
    check("slow wdata", d, 32'h0000_0077);
    check("slow rx_ready at b", 32'(rb), 32'd1);
    rx_valid = 1'b0;

    // Error response on a poll is sticky
    axi_read("err poll", 32'h00, 2'b10, a, wc);
    check("err bridge_err", 32'(bridge_err), 32'd1);
`ifdef AXI_UART_BRIDGE_ERR_CNT_EN
    check("err count", 32'(err_count), 32'd1);
`endif
    axi_read("ok poll", 32'h00, 2'b00, a, wc);
    check("err sticky", 32'(bridge_err), 32'd1);
`ifdef AXI_UART_BRIDGE_ERR_CNT_EN
    check("err count held", 32'(err_count), 32'd1);
`endif

    // New probe byte cuts the gap short
    repeat (3) tick();
    rx_valid = 1'b1;
    rx_data  = 8'h99;
    axi_read("early poll", 32'h04, 2'b00, a, wc);
    check("early poll wait", 32'(wc), 32'd1);

    // Async reset in WR_AW
    wc = 0;
    while (!bus.awvalid && wc < 50) begin
      tick();
      wc++;
    end
    check("pre-rst awvalid", 32'(bus.awvalid), 32'd1);
    m_aresetn = 1'b0;
    #1;
    check("mid-rst awvalid", 32'(bus.awvalid), 32'd0);
    check("mid-rst wvalid", 32'(bus.wvalid), 32'd0);
    check("mid-rst arvalid", 32'(bus.arvalid), 32'd0);
    check("mid-rst bridge_err", 32'(bridge_err), 32'd0);
    check("mid-rst rx_ready", 32'(rx_ready), 32'd0);
    tick();
    m_aresetn = 1'b1;
    axi_write("re-cfg", 0, a, d, awh, wh, rb, ra, arb);
    check("re-cfg awaddr", a, A_CTRL);
    check("re-cfg rx_ready", 32'(rb), 32'd0);
    rx_valid = 1'b0;

    check("ar/aw exclusive", 32'(overlap), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
